// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared sizes and state encoding for the instruction-memory fetch sequencer.
package instr_fetch_ctrl_pkg;

   localparam int unsigned ADDR_WIDTH = 8;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WR_WIN     = 4;
   localparam int unsigned RD_WIN     = 8;
   localparam int unsigned LOG_WR_WIN = 2;
   localparam int unsigned LOG_RD_WIN = 3;

   // One extra bit so bounds arithmetic on pointers cannot wrap.
   localparam int unsigned ADDR_EXT_W = ADDR_WIDTH + 1;
   localparam int unsigned RD_CNT_W   = LOG_RD_WIN + 1;
   localparam int unsigned MAX_PROG   = (2 ** ADDR_WIDTH) - 1;

   typedef enum logic [2:0] {
      StLoad  = 3'd0,
      StFlush = 3'd1,
      StRun   = 3'd2,
      StDone  = 3'd3,
      StErr   = 3'd4
   } state_e;

endpackage

// File: rtl/instr_fetch_ctrl_byte_packer.sv
// Packs loader bytes into write windows and issues full or final partial writes
// one cycle after the window closes; tracks the committed write pointer.
module instr_byte_packer
   import instr_fetch_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       accept,
   input  logic                       ld_last,
   input  logic [BYTE_W-1:0]          ld_byte,
   output logic [LOG_WR_WIN-1:0]      pack_cnt,
   output logic [ADDR_WIDTH-1:0]      wr_ptr,
   output logic                       mem_we,
   output logic [LOG_WR_WIN-1:0]      mem_wr_shift_minusone,
   output logic [WR_WIN*BYTE_W-1:0]   mem_wr_data
);

   logic [WR_WIN-1:0][BYTE_W-1:0] pack_q, pack_d, win_data;
   logic [LOG_WR_WIN-1:0]         cnt_q;
   logic [ADDR_WIDTH-1:0]         wr_ptr_q;
   logic                          we_q;
   logic [LOG_WR_WIN-1:0]         sm1_q;
   logic [WR_WIN*BYTE_W-1:0]      data_q;
   logic                          win_close;

   assign win_close = accept && (ld_last || (cnt_q == LOG_WR_WIN'(WR_WIN - 1)));

   always_comb begin
      pack_d = pack_q;
      if (accept) begin
         pack_d[cnt_q] = ld_byte;
      end
      // Lanes beyond the bytes actually written are driven as zero.
      win_data = '0;
      for (int i = 0; i < WR_WIN; i++) begin
         if (i <= int'(cnt_q)) begin
            win_data[i] = pack_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pack_q   <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         we_q     <= 1'b0;
         sm1_q    <= '0;
         data_q   <= '0;
      end else begin
         we_q <= win_close;
         if (accept) begin
            pack_q <= pack_d;
         end
         if (win_close) begin
            cnt_q    <= '0;
            sm1_q    <= cnt_q;
            data_q   <= win_data;
            wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
         end else if (accept) begin
            cnt_q <= cnt_q + LOG_WR_WIN'(1);
         end
      end
   end

   assign pack_cnt              = cnt_q;
   assign wr_ptr                = wr_ptr_q;
   assign mem_we                = we_q;
   assign mem_wr_shift_minusone = sm1_q;
   assign mem_wr_data           = data_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction-memory sequencer: loads the program through the byte packer, then
// forwards bounds-checked decoder consume/jump requests to the memory read side.
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_vld,
   output logic                       ld_rdy,
   input  logic [BYTE_W-1:0]          ld_byte,
   input  logic                       ld_last,
   output logic                       mem_we,
   output logic [LOG_WR_WIN-1:0]      mem_wr_shift_minusone,
   output logic [WR_WIN*BYTE_W-1:0]   mem_wr_data,
   output logic                       mem_re,
   output logic                       mem_shift_vld,
   output logic [LOG_RD_WIN-1:0]      mem_rd_shift_minusone,
   output logic                       mem_jump_en,
   output logic [ADDR_WIDTH-1:0]      mem_jump_addr,
   output logic                       dec_win_vld,
   output logic [LOG_RD_WIN:0]        dec_avail,
   input  logic                       dec_consume_vld,
   input  logic [LOG_RD_WIN-1:0]      dec_consume_minusone,
   input  logic                       dec_jump_vld,
   input  logic [ADDR_WIDTH-1:0]      dec_jump_addr,
   output logic [ADDR_WIDTH-1:0]      prog_len,
   output logic                       done,
   output logic                       err
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr;
   logic [LOG_WR_WIN-1:0]   pack_cnt;
   logic [ADDR_EXT_W-1:0]   ld_total;
   logic                    ld_ovf, ld_accept;
   logic [ADDR_EXT_W-1:0]   remain, jump_end;
   logic [RD_CNT_W-1:0]     avail, cons_len;
   logic                    cons_bad, cons_fwd;

   // Bytes held (committed plus packed) if the offered byte were taken.
   assign ld_total  = {1'b0, wr_ptr} + ADDR_EXT_W'(pack_cnt) + ADDR_EXT_W'(1);
   assign ld_ovf    = ld_total > ADDR_EXT_W'(MAX_PROG);
   assign ld_accept = (state_q == StLoad) && ld_vld && !ld_ovf;

   instr_byte_packer u_packer (
      .clk                   (clk),
      .rst                   (rst),
      .accept                (ld_accept),
      .ld_last               (ld_last),
      .ld_byte               (ld_byte),
      .pack_cnt              (pack_cnt),
      .wr_ptr                (wr_ptr),
      .mem_we                (mem_we),
      .mem_wr_shift_minusone (mem_wr_shift_minusone),
      .mem_wr_data           (mem_wr_data)
   );

   assign remain   = {1'b0, wr_ptr} - {1'b0, rd_ptr_q};
   assign avail    = (remain > ADDR_EXT_W'(RD_WIN)) ? RD_CNT_W'(RD_WIN) : remain[RD_CNT_W-1:0];
   assign cons_len = {1'b0, dec_consume_minusone} + RD_CNT_W'(1);
   assign jump_end = {1'b0, dec_jump_addr} + ADDR_EXT_W'(cons_len);
   assign cons_bad = dec_jump_vld ? ((dec_jump_addr >= wr_ptr) || (jump_end > {1'b0, wr_ptr}))
                                  : (cons_len > avail);
   assign cons_fwd = dec_consume_vld && !cons_bad;
   assign rd_ptr_d = (dec_jump_vld ? dec_jump_addr : rd_ptr_q) + ADDR_WIDTH'(cons_len);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StLoad;
         rd_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == StRun) && cons_fwd) begin
            rd_ptr_q <= rd_ptr_d;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StLoad: begin
            if (ld_vld && ld_ovf) begin
               state_d = StErr;
            end else if (ld_accept && ld_last) begin
               state_d = StFlush;
            end
         end
         StFlush: state_d = StRun;
         StRun: begin
            if (dec_consume_vld) begin
               if (cons_bad) begin
                  state_d = StErr;
               end else if (rd_ptr_d == wr_ptr) begin
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StDone;
         StErr:   state_d = StErr;
         default: state_d = StErr;
      endcase
   end

   always_comb begin
      ld_rdy                = 1'b0;
      mem_re                = 1'b0;
      dec_win_vld           = 1'b0;
      dec_avail             = '0;
      mem_shift_vld         = 1'b0;
      mem_rd_shift_minusone = '0;
      mem_jump_en           = 1'b0;
      mem_jump_addr         = '0;
      done                  = 1'b0;
      err                   = 1'b0;
      case (state_q)
         StLoad: ld_rdy = 1'b1;
         StRun: begin
            mem_re      = 1'b1;
            dec_win_vld = rd_ptr_q < wr_ptr;
            dec_avail   = avail;
            if (cons_fwd) begin
               mem_shift_vld         = 1'b1;
               mem_rd_shift_minusone = dec_consume_minusone;
               mem_jump_en           = dec_jump_vld;
               if (dec_jump_vld) begin
                  mem_jump_addr = dec_jump_addr;
               end
            end
         end
         StDone:  done = 1'b1;
         StErr:   err  = 1'b1;
         default: ;
      endcase
   end

   assign prog_len = wr_ptr;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed load checks, a vector table for the RUN
// side, reset/overflow sequences and a randomized run against a simple model.
module tb_instr_fetch_ctrl;
   import instr_fetch_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_vld, ld_rdy, ld_last;
   logic [7:0]  ld_byte;
   logic        mem_we;
   logic [1:0]  mem_wr_shift_minusone;
   logic [31:0] mem_wr_data;
   logic        mem_re, mem_shift_vld, mem_jump_en;
   logic [2:0]  mem_rd_shift_minusone;
   logic [7:0]  mem_jump_addr;
   logic        dec_win_vld;
   logic [3:0]  dec_avail;
   logic        dec_consume_vld, dec_jump_vld;
   logic [2:0]  dec_consume_minusone;
   logic [7:0]  dec_jump_addr;
   logic [7:0]  prog_len;
   logic        done, err;

   always #5 clk = ~clk;

   instr_fetch_ctrl dut (
      .clk                   (clk),
      .rst                   (rst),
      .ld_vld                (ld_vld),
      .ld_rdy                (ld_rdy),
      .ld_byte               (ld_byte),
      .ld_last               (ld_last),
      .mem_we                (mem_we),
      .mem_wr_shift_minusone (mem_wr_shift_minusone),
      .mem_wr_data           (mem_wr_data),
      .mem_re                (mem_re),
      .mem_shift_vld         (mem_shift_vld),
      .mem_rd_shift_minusone (mem_rd_shift_minusone),
      .mem_jump_en           (mem_jump_en),
      .mem_jump_addr         (mem_jump_addr),
      .dec_win_vld           (dec_win_vld),
      .dec_avail             (dec_avail),
      .dec_consume_vld       (dec_consume_vld),
      .dec_consume_minusone  (dec_consume_minusone),
      .dec_jump_vld          (dec_jump_vld),
      .dec_jump_addr         (dec_jump_addr),
      .prog_len              (prog_len),
      .done                  (done),
      .err                   (err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [1:0]  sm1;
      logic [31:0] data;
   } wr_t;
   wr_t wr_log[$];

   always @(negedge clk) begin
      if (mem_we === 1'b1) wr_log.push_back(wr_t'{mem_wr_shift_minusone, mem_wr_data});
   end

   logic [7:0] prog_bytes[256];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ld_vld               = 1'b0;
      ld_last              = 1'b0;
      ld_byte              = 8'h00;
      dec_consume_vld      = 1'b0;
      dec_consume_minusone = 3'd0;
      dec_jump_vld         = 1'b0;
      dec_jump_addr        = 8'h00;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      wr_log.delete();
   endtask

   task automatic load_prog(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               ld_vld = 1'b0;
               tick();
            end
         end
         ld_vld  = 1'b1;
         ld_byte = prog_bytes[i];
         ld_last = (i == n - 1);
         tick();
      end
      ld_vld  = 1'b0;
      ld_last = 1'b0;
      for (int k = 0; k < 4 && mem_re !== 1'b1; k++) tick();
      check("load_reaches_run", mem_re, 1);
   endtask

   // Expected writes: the program split into 4-byte chunks, last one possibly short.
   task automatic check_writes(input int n);
      int nw, sz;
      nw = (n + 3) / 4;
      check("wr_count", wr_log.size(), nw);
      for (int w = 0; w < nw && w < wr_log.size(); w++) begin
         sz = (n - 4 * w >= 4) ? 4 : n - 4 * w;
         check($sformatf("wr%0d_shift_m1", w), wr_log[w].sm1, sz - 1);
         for (int b = 0; b < sz; b++) begin
            check($sformatf("wr%0d_byte%0d", w, b), wr_log[w].data[8*b +: 8],
                  prog_bytes[4*w + b]);
         end
      end
      check("prog_len", prog_len, n);
   endtask

   typedef struct {
      bit         reload;
      bit         cv;
      logic [2:0] m1;
      bit         jv;
      logic [7:0] ja;
      int         exp_avail;
      bit         exp_shift;
      bit         exp_jump;
      bit         exp_done;
      bit         exp_err;
   } vec_t;
   vec_t vecs[$];

   // Random-run model state: 0 running, 1 done, 2 error.
   int  n, m_rd, m_st, m_avail, len, ja_i;
   bit  cv, jv, bad, exp_shift;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_ld_rdy", ld_rdy, 1);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_shift", mem_shift_vld, 0);
      check("rst_win_vld", dec_win_vld, 0);
      check("rst_avail", dec_avail, 0);
      check("rst_prog_len", prog_len, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);

      // 8-byte program: two full windows
      for (int b = 0; b < 8; b++) prog_bytes[b] = 8'(b);
      load_prog(8, 0);
      check_writes(8);
      if (wr_log.size() == 2) begin
         check("wr8_word0", wr_log[0].data, 32'h03020100);
         check("wr8_word1", wr_log[1].data, 32'h07060504);
      end
      check("run8_avail", dec_avail, 8);

      // 6-byte program: full window plus 2-byte flush
      do_reset();
      for (int b = 0; b < 6; b++) prog_bytes[b] = 8'(8'h10 + b);
      load_prog(6, 0);
      check_writes(6);

      // RUN-side vector table on a 10-byte program
      vecs.push_back('{1, 1, 3'd2, 0, 8'd0,  8, 1, 0, 0, 0});
      vecs.push_back('{0, 1, 3'd2, 0, 8'd0,  7, 1, 0, 0, 0});
      vecs.push_back('{0, 1, 3'd3, 0, 8'd0,  4, 1, 0, 1, 0});
      vecs.push_back('{0, 1, 3'd0, 0, 8'd0,  0, 0, 0, 1, 0});
      vecs.push_back('{1, 1, 3'd5, 0, 8'd0,  8, 1, 0, 0, 0});
      vecs.push_back('{0, 1, 3'd1, 1, 8'd2,  4, 1, 1, 0, 0});
      vecs.push_back('{0, 0, 3'd0, 0, 8'd0,  6, 0, 0, 0, 0});
      vecs.push_back('{0, 1, 3'd0, 1, 8'd12, 6, 0, 0, 0, 1});
      vecs.push_back('{0, 1, 3'd0, 0, 8'd0,  0, 0, 0, 0, 1});
      vecs.push_back('{1, 1, 3'd7, 0, 8'd0,  8, 1, 0, 0, 0});
      vecs.push_back('{0, 1, 3'd2, 0, 8'd0,  2, 0, 0, 0, 1});
      vecs.push_back('{1, 1, 3'd1, 1, 8'd9,  8, 0, 0, 0, 1});
      vecs.push_back('{1, 1, 3'd0, 1, 8'd10, 8, 0, 0, 0, 1});
      vecs.push_back('{1, 1, 3'd1, 1, 8'd8,  8, 1, 1, 1, 0});
      foreach (vecs[i]) begin
         if (vecs[i].reload) begin
            do_reset();
            for (int b = 0; b < 10; b++) prog_bytes[b] = 8'(8'h40 + b);
            load_prog(10, 0);
         end
         dec_consume_vld      = vecs[i].cv;
         dec_consume_minusone = vecs[i].m1;
         dec_jump_vld         = vecs[i].jv;
         dec_jump_addr        = vecs[i].ja;
         @(negedge clk);
         check($sformatf("v%0d_avail", i), dec_avail, vecs[i].exp_avail);
         check($sformatf("v%0d_win_vld", i), dec_win_vld, vecs[i].exp_avail > 0);
         check($sformatf("v%0d_shift_vld", i), mem_shift_vld, vecs[i].exp_shift);
         check($sformatf("v%0d_jump_en", i), mem_jump_en, vecs[i].exp_jump);
         if (vecs[i].exp_shift) check($sformatf("v%0d_shift_m1", i), mem_rd_shift_minusone,
                                      vecs[i].m1);
         if (vecs[i].exp_jump) check($sformatf("v%0d_jump_addr", i), mem_jump_addr,
                                     vecs[i].ja);
         tick();
         idle_inputs();
         check($sformatf("v%0d_done", i), done, vecs[i].exp_done);
         check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
         check($sformatf("v%0d_mem_re", i), mem_re, !(vecs[i].exp_done || vecs[i].exp_err));
      end

      // Overflow: 255 bytes fit, the 256th is refused
      do_reset();
      for (int i = 0; i < 255; i++) begin
         ld_vld  = 1'b1;
         ld_byte = 8'(i);
         tick();
      end
      check("ovf_err_before", err, 0);
      check("ovf_rdy_before", ld_rdy, 1);
      ld_byte = 8'hFF;
      tick();
      ld_vld = 1'b0;
      check("ovf_err", err, 1);
      check("ovf_ld_rdy", ld_rdy, 0);
      tick();
      tick();
      check("ovf_write_count", wr_log.size(), 63);

      // Reset mid-load while a window is closing
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ld_vld  = 1'b1;
         ld_byte = 8'(8'h20 + i);
         tick();
      end
      ld_byte = 8'h23;
      rst     = 1'b1;
      tick();
      rst    = 1'b0;
      ld_vld = 1'b0;
      @(negedge clk);
      check("midrst_mem_we", mem_we, 0);
      check("midrst_ld_rdy", ld_rdy, 1);
      tick();
      tick();
      check("midrst_no_write", wr_log.size(), 0);
      for (int b = 0; b < 4; b++) prog_bytes[b] = 8'(8'h30 + b);
      load_prog(4, 0);
      check_writes(4);

      // Randomized programs and decoder traffic against the model
      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(1, 40);
         do_reset();
         for (int b = 0; b < n; b++) prog_bytes[b] = 8'($urandom);
         load_prog(n, 1);
         check_writes(n);
         m_rd = 0;
         m_st = 0;
         for (int s = 0; s < 25; s++) begin
            m_avail = (m_st == 0) ? ((n - m_rd > 8) ? 8 : n - m_rd) : 0;
            cv = ($urandom_range(0, 3) != 0);
            jv = ($urandom_range(0, 4) == 0);
            if (!jv && m_avail > 0 && $urandom_range(0, 5) != 0) len = $urandom_range(1, m_avail);
            else len = $urandom_range(1, 8);
            ja_i = $urandom_range(0, n + 3);
            dec_consume_vld      = cv;
            dec_consume_minusone = 3'(len - 1);
            dec_jump_vld         = jv;
            dec_jump_addr        = 8'(ja_i);
            bad = jv ? (ja_i >= n || ja_i + len > n) : (len > m_avail);
            exp_shift = (m_st == 0) && cv && !bad;
            @(negedge clk);
            check("rnd_avail", dec_avail, m_avail);
            check("rnd_win_vld", dec_win_vld, (m_st == 0) && (m_rd < n));
            check("rnd_shift_vld", mem_shift_vld, exp_shift);
            check("rnd_jump_en", mem_jump_en, exp_shift && jv);
            check("rnd_mem_re", mem_re, m_st == 0);
            tick();
            idle_inputs();
            if (m_st == 0 && cv) begin
               if (bad) m_st = 2;
               else begin
                  m_rd = (jv ? ja_i : m_rd) + len;
                  if (m_rd == n) m_st = 1;
               end
            end
            check("rnd_done", done, m_st == 1);
            check("rnd_err", err, m_st == 2);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequencer for the byte-addressed instruction memory.
- LOAD phase: accepts the program byte stream from the host loader, packs bytes into write windows and drives the memory write port.
- RUN phase: exposes the read window to the decoder, converts decoder consume/jump requests into memory shift/jump commands and bounds-checks them.
- Keeps shadow copies of the write and read pointers so it can compute occupancy, end-of-program and errors.

Parameters:
- ADDR_WIDTH, 8, instruction memory address width; depth = 2**ADDR_WIDTH bytes.
- BYTE_W, 8, bits per memory entry.
- WR_WIN, 4, bytes per write window.
- RD_WIN, 8, bytes per read window.
- LOG_WR_WIN, 2, width of the write shift-minus-one field.
- LOG_RD_WIN, 3, width of the read shift-minus-one field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ld_vld  in  1  loader byte valid.
- ld_rdy  out  1  controller accepts a byte this cycle.
- ld_byte  in  BYTE_W  program byte.
- ld_last  in  1  marks the final program byte.
- mem_we  out  1  write window strobe.
- mem_wr_shift_minusone  out  LOG_WR_WIN  bytes written minus one.
- mem_wr_data  out  WR_WIN*BYTE_W  packed bytes; byte 0 in the LSBs.
- mem_re  out  1  read window enable.
- mem_shift_vld  out  1  advance the memory read pointer.
- mem_rd_shift_minusone  out  LOG_RD_WIN  bytes consumed minus one.
- mem_jump_en  out  1  jump qualifier for the memory.
- mem_jump_addr  out  ADDR_WIDTH  jump target.
- dec_win_vld  out  1  read window is valid for the decoder.
- dec_avail  out  LOG_RD_WIN+1  valid bytes in the window, min(RD_WIN, end-rd_ptr).
- dec_consume_vld  in  1  decoder consumed bytes.
- dec_consume_minusone  in  LOG_RD_WIN  bytes consumed minus one.
- dec_jump_vld  in  1  consume is relative to dec_jump_addr.
- dec_jump_addr  in  ADDR_WIDTH  jump target.
- prog_len  out  ADDR_WIDTH  loaded byte count.
- done  out  1  read pointer reached end of program.
- err  out  1  sticky error flag.

Behaviour:
- States are LOAD, FLUSH, RUN, DONE and ERR. Reset enters LOAD.
- Reset values: wr_ptr=0, rd_ptr=0, pack_cnt=0. All outputs are 0 except ld_rdy=1.
- LOAD, handshake and packing:
  - ld_rdy = (state==LOAD).
  - A byte is accepted when ld_vld && ld_rdy. It is stored at pack[pack_cnt] and pack_cnt increments.
  - When the WR_WIN-th byte is accepted, the next cycle has mem_we=1 and mem_wr_shift_minusone=WR_WIN-1, with mem_wr_data latched. wr_ptr advances by WR_WIN on that cycle. Latency is 1 cycle.
  - Byte acceptance continues in the same cycle as mem_we; there are no bubbles.
- LOAD to FLUSH on an accepted ld_last byte:
  - If the window is complete, FLUSH issues a full write (WR_WIN bytes).
  - Otherwise FLUSH issues a partial write of pack_cnt bytes, with shift_minusone = pack_cnt-1.
  - FLUSH lasts one cycle, then goes to RUN. prog_len = final wr_ptr.
- Overflow: if accepting a byte would make the total exceed 2**ADDR_WIDTH-1, enter ERR.
  - The offending byte is not accepted and no write is issued.
  - The limit of 2**ADDR_WIDTH-1 keeps rd_ptr==wr_ptr unambiguous.
- RUN:
  - mem_re=1.
  - dec_win_vld=1 while rd_ptr<prog_len.
  - dec_avail = min(RD_WIN, prog_len-rd_ptr).
- Consume and jump (combinational pass-through in the same cycle, because the memory updates on the next edge):
  - On dec_consume_vld: mem_shift_vld=1 and mem_rd_shift_minusone=dec_consume_minusone.
  - mem_jump_en = dec_jump_vld && dec_consume_vld.
  - mem_jump_addr = dec_jump_addr.
  - Shadow update: rd_ptr <= (jump ? dec_jump_addr : rd_ptr) + minusone + 1.
- Errors in RUN, evaluated before any forwarding:
  - A non-jump consume of more than dec_avail bytes is an error.
  - A jump with dec_jump_addr >= prog_len is an error.
  - A jump whose target plus length exceeds prog_len is an error.
  - On error: enter ERR, hold mem_shift_vld=0 and mem_jump_en=0, and leave rd_ptr unchanged.
- RUN to DONE when the updated rd_ptr == prog_len. DONE asserts done=1 and mem_re=0.
- DONE and ERR are terminal until rst. Consume or jump inputs are ignored in LOAD, FLUSH, DONE and ERR.
- rst mid-load discards the pack register and returns to LOAD. No mem_we is issued in the cycle following rst.
- All pointer arithmetic is ADDR_WIDTH bits. Bounds checks use ADDR_WIDTH+1 bits so they cannot wrap.

Decomposition:
- Shared package or defines file: ADDR_WIDTH, BYTE_W, WR_WIN, RD_WIN, LOG_* widths, and the state encoding (3-bit localparams).
- One sub-module: instr_byte_packer, covering the pack register, pack_cnt, full/flush write generation and wr_ptr.
- The FSM, bounds checks and RUN-side forwarding stay in instr_fetch_ctrl.

Test Plan:
- Load 8 bytes 0x00..0x07 with ld_last on 0x07. Expect two mem_we pulses with shift_minusone=3, data 0x03020100 then 0x07060504. Expect prog_len=8, then RUN.
- Load 6 bytes. Expect one full write, then a FLUSH write with shift_minusone=1 and data bytes 4-5. Expect prog_len=6.
- Run a 10-byte program with consumes of 3, 3 and 4. Expect dec_avail to step 8, 7, 4. Expect mem_shift_vld on each consume, done=1 after the last, and mem_re=0 in DONE.
- At rd_ptr=6 in a 10-byte program, jump to 2 with length 2. Expect mem_jump_en=1, mem_jump_addr=2, and shadow rd_ptr=4.
- Jump to 12 in a 10-byte program. Expect err=1, no mem_shift_vld, state ERR.
- Stream 256 bytes with ADDR_WIDTH=8. Expect the 256th byte to be rejected, err=1, and ld_rdy=0. Apply rst mid-load: expect pack_cnt cleared and no mem_we.
